array_io_sequencer: RTL and testbench

ARRAY_IO_SEQUENCER -- requirements
Module: array_io_sequencer

---
 rtl/cgra_pkg.sv | 20 ++
 rtl/io_delay_line.sv | 32 +++
 rtl/array_io_sequencer.sv | 166 ++++++++++++++++
 tb/tb_array_io_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: IO sequencer state encoding and drain timing.
package cgra_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // Width of the drain-cycle counter; covers the longest drain (2 + 15).
  localparam int DRAIN_CNT_W = 5;

  // Cycles between the last read strobe and the last output write:
  // one cycle of buffer read latency, one load register, then the array.
  function automatic int drain_len(input int store_lat);
    return 2 + store_lat;
  endfunction

endpackage

// File: rtl/io_delay_line.sv
// Single-bit shift register that turns the read strobe into the write strobe.
module io_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Shift one position per cycle, new bit entering at the bottom.
  always_comb begin
    shift_d    = shift_q << 1;
    shift_d[0] = d_i;
  end

  // State register; reset and cancel both empty the line.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      shift_q <= {DEPTH{1'b0}};
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/array_io_sequencer.sv
// Streams a run of words from the two input banks into the PE array's IO
// ports and writes the returned words to the output buffer.
import cgra_pkg::*;

module array_io_sequencer #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int STORE_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [AWIDTH-1:0] Run_Len,
  input  logic              Abort,
  output logic              In_Rd_En,
  output logic [AWIDTH-1:0] In_Addr,
  input  logic [DWIDTH-1:0] In0_Rd_Data,
  input  logic [DWIDTH-1:0] In1_Rd_Data,
  output logic [DWIDTH-1:0] Data0_Load,
  output logic [DWIDTH-1:0] Data1_Load,
  input  logic [DWIDTH-1:0] Data0_Store,
  input  logic [DWIDTH-1:0] Data1_Store,
  output logic              Out_Wr_En,
  output logic [AWIDTH-1:0] Out_Addr,
  output logic [DWIDTH-1:0] Out0_Wr_Data,
  output logic [DWIDTH-1:0] Out1_Wr_Data,
  output logic              PE_Array_Busy,
  output logic              Done
);

  localparam int                     DRAIN_LEN  = drain_len(STORE_LAT);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_LEN - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);
  localparam logic [AWIDTH-1:0]      ADDR_ONE   = AWIDTH'(1);
  localparam logic [AWIDTH-1:0]      ADDR_ZERO  = {AWIDTH{1'b0}};

  seq_state_e             state_q, state_d;
  logic [AWIDTH-1:0]      len_q, len_d;
  logic [AWIDTH-1:0]      rd_cnt_q, rd_cnt_d;
  logic [AWIDTH-1:0]      wr_cnt_q, wr_cnt_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0]      load0_q, load0_d;
  logic [DWIDTH-1:0]      load1_q, load1_d;
  logic                   rd_en_s;
  logic                   wr_en_s;

  assign rd_en_s = (state_q == SEQ_RUN);

  // Write strobe is the read strobe delayed by the full load/array latency.
  io_delay_line #(
    .DEPTH (DRAIN_LEN)
  ) u_wr_delay (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (Abort),
    .d_i   (rd_en_s),
    .q_o   (wr_en_s)
  );

  // Next-state, counter and load-register logic; Abort overrides everything.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    drain_cnt_d = {DRAIN_CNT_W{1'b0}};
    rd_valid_d  = rd_en_s;
    load0_d     = load0_q;
    load1_d     = load1_q;

    if (wr_en_s) begin
      wr_cnt_d = wr_cnt_q + ADDR_ONE;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (rd_valid_q) begin
      load0_d = In0_Rd_Data;
      load1_d = In1_Rd_Data;
    end else begin
      load0_d = load0_q;
      load1_d = load1_q;
    end

    case (state_q)
      SEQ_IDLE: begin
        if (Start) begin
          len_d    = Run_Len;
          rd_cnt_d = ADDR_ZERO;
          wr_cnt_d = ADDR_ZERO;
          state_d  = (Run_Len == ADDR_ZERO) ? SEQ_DONE : SEQ_RUN;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        rd_cnt_d = rd_cnt_q + ADDR_ONE;
        if (rd_cnt_q == (len_q - ADDR_ONE)) begin
          state_d = SEQ_DRAIN;
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = SEQ_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_ONE;
          state_d     = SEQ_DRAIN;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    if (Abort) begin
      state_d     = SEQ_IDLE;
      rd_cnt_d    = ADDR_ZERO;
      wr_cnt_d    = ADDR_ZERO;
      drain_cnt_d = {DRAIN_CNT_W{1'b0}};
      rd_valid_d  = 1'b0;
    end else begin
      rd_valid_d  = rd_valid_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= SEQ_IDLE;
      len_q       <= ADDR_ZERO;
      rd_cnt_q    <= ADDR_ZERO;
      wr_cnt_q    <= ADDR_ZERO;
      drain_cnt_q <= {DRAIN_CNT_W{1'b0}};
      rd_valid_q  <= 1'b0;
      load0_q     <= {DWIDTH{1'b0}};
      load1_q     <= {DWIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_valid_q  <= rd_valid_d;
      load0_q     <= load0_d;
      load1_q     <= load1_d;
    end
  end

  assign In_Rd_En      = rd_en_s;
  assign In_Addr       = rd_cnt_q;
  assign Out_Wr_En     = wr_en_s;
  assign Out_Addr      = wr_cnt_q;
  assign Data0_Load    = load0_q;
  assign Data1_Load    = load1_q;
  assign Out0_Wr_Data  = wr_en_s ? Data0_Store : {DWIDTH{1'b0}};
  assign Out1_Wr_Data  = wr_en_s ? Data1_Store : {DWIDTH{1'b0}};
  assign PE_Array_Busy = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
  assign Done          = (state_q == SEQ_DONE);

endmodule

// File: tb/tb_array_io_sequencer.sv
// Directed bench for array_io_sequencer with a run-timeline reference model.
module tb_array_io_sequencer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SL = 2;
  localparam int D  = 2 + SL;

  logic          Clk = 1'b0;
  logic          Reset, Start, Abort;
  logic [AW-1:0] Run_Len;
  logic          In_Rd_En, Out_Wr_En, PE_Array_Busy, Done;
  logic [AW-1:0] In_Addr, Out_Addr;
  logic [DW-1:0] In0_Rd_Data = '0;
  logic [DW-1:0] In1_Rd_Data = '0;
  logic [DW-1:0] Data0_Load, Data1_Load, Data0_Store, Data1_Store;
  logic [DW-1:0] Out0_Wr_Data, Out1_Wr_Data;

  always #5 Clk = ~Clk;

  array_io_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .STORE_LAT(SL)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Run_Len(Run_Len), .Abort(Abort),
    .In_Rd_En(In_Rd_En), .In_Addr(In_Addr),
    .In0_Rd_Data(In0_Rd_Data), .In1_Rd_Data(In1_Rd_Data),
    .Data0_Load(Data0_Load), .Data1_Load(Data1_Load),
    .Data0_Store(Data0_Store), .Data1_Store(Data1_Store),
    .Out_Wr_En(Out_Wr_En), .Out_Addr(Out_Addr),
    .Out0_Wr_Data(Out0_Wr_Data), .Out1_Wr_Data(Out1_Wr_Data),
    .PE_Array_Busy(PE_Array_Busy), .Done(Done)
  );

  function automatic logic [DW-1:0] word0(input int k);
    return DW'(k + 100);
  endfunction
  function automatic logic [DW-1:0] word1(input int k);
    return DW'(k + 200);
  endfunction

  // Input banks: registered read, data one cycle after the strobe.
  always @(posedge Clk) begin
    if (In_Rd_En === 1'b1) begin
      In0_Rd_Data <= word0(int'(In_Addr));
      In1_Rd_Data <= word1(int'(In_Addr));
    end
  end

  // PE array IO model: echoes loads after SL cycles.
  logic [DW-1:0] st0 [SL];
  logic [DW-1:0] st1 [SL];
  always @(posedge Clk) begin
    st0[0] <= Data0_Load;
    st1[0] <= Data1_Load;
    for (int i = 1; i < SL; i++) begin
      st0[i] <= st0[i-1];
      st1[i] <= st1[i-1];
    end
  end
  assign Data0_Store = st0[SL-1];
  assign Data1_Store = st1[SL-1];

  int checks = 0;
  int errors = 0;

  // Reference model: one accepted run described by its start/end cycles.
  int            cyc = 0;
  bit            live = 1'b0;
  int            run_s, run_e, run_n;
  int            hold_in = 0, hold_out = 0;
  logic [DW-1:0] ld0 = '0, ld1 = '0;
  bit            p_v = 1'b0;
  int            p_a = 0;

  // Per-segment observations.
  int            n_rd, n_wr, n_busy, n_done, first_busy, done_at;
  int            wa_q[$];
  logic [DW-1:0] w0_q[$];
  logic [DW-1:0] w1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0; first_busy = -1; done_at = -1;
    wa_q.delete(); w0_q.delete(); w1_q.delete();
  endtask

  // Compare this cycle's outputs, record stats, apply this cycle's inputs to the model.
  task automatic tick();
    int rel, e_ia, e_oa;
    bit e_rd, e_wr, e_busy, e_done;
    e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_ia = hold_in; e_oa = hold_out;
    if (live) begin
      e_ia = 0; e_oa = 0;
      if (run_n > 0) begin
        rel    = cyc - run_s;
        e_rd   = (rel < run_n);
        e_ia   = (rel < run_n) ? rel : run_n;
        e_wr   = (rel >= D) && (rel < D + run_n);
        e_oa   = (rel < D) ? 0 : ((rel < D + run_n) ? rel - D : run_n);
        e_busy = (rel < run_n + D);
      end
      e_done = (cyc == run_e);
    end
    chk("rd_en", In_Rd_En, e_rd);
    chk("in_addr", In_Addr, e_ia);
    chk("wr_en", Out_Wr_En, e_wr);
    chk("out_addr", Out_Addr, e_oa);
    chk("busy", PE_Array_Busy, e_busy);
    chk("done", Done, e_done);
    chk("load0", Data0_Load, ld0);
    chk("load1", Data1_Load, ld1);
    if (e_wr) begin
      chk("wr_data0", Out0_Wr_Data, word0(e_oa));
      chk("wr_data1", Out1_Wr_Data, word1(e_oa));
    end
    if (In_Rd_En === 1'b1) n_rd++;
    if (PE_Array_Busy === 1'b1) begin
      n_busy++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (Done === 1'b1) begin n_done++; done_at = cyc; end
    if (Out_Wr_En === 1'b1) begin
      n_wr++; wa_q.push_back(int'(Out_Addr));
      w0_q.push_back(Out0_Wr_Data); w1_q.push_back(Out1_Wr_Data);
    end
    if (Reset) begin
      live = 1'b0; hold_in = 0; hold_out = 0; ld0 = '0; ld1 = '0; p_v = 1'b0;
    end else begin
      if (p_v) begin ld0 = word0(p_a); ld1 = word1(p_a); end
      p_v = e_rd && !Abort;
      p_a = e_ia;
      if (Abort) begin
        live = 1'b0; hold_in = 0; hold_out = 0;
      end else if (live && cyc == run_e) begin
        live = 1'b0; hold_in = run_n; hold_out = run_n;
      end else if (!live && Start) begin
        live  = 1'b1;
        run_n = int'(Run_Len);
        run_s = cyc + 1;
        run_e = (run_n > 0) ? run_s + run_n + D : cyc + 1;
        hold_in = 0; hold_out = 0;
      end
    end
    cyc++;
    @(negedge Clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic check_writes(input string tag, input int exp_n);
    chk({tag, "_nwr"}, n_wr, exp_n);
    for (int i = 0; i < exp_n && i < wa_q.size(); i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wa_q[i], i);
      chk($sformatf("%s_wd0_%0d", tag, i), w0_q[i], 100 + i);
      chk($sformatf("%s_wd1_%0d", tag, i), w1_q[i], 200 + i);
    end
  endtask

  task automatic start_run(input int n);
    Start = 1'b1; Run_Len = AW'(n);
    tick();
    Start = 1'b0;
  endtask

  int start_c;

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Run_Len = '0;
    clear_stats();
    @(negedge Clk);
    chk("rst_rd_en", In_Rd_En, 1'b0);
    chk("rst_wr_en", Out_Wr_En, 1'b0);
    chk("rst_busy", PE_Array_Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_load0", Data0_Load, 0);
    ticks(2);
    Reset = 1'b0;
    ticks(2);

    // Basic N=4 run.
    clear_stats(); start_c = cyc;
    start_run(4);
    ticks(12);
    check_writes("n4", 4);
    chk("n4_nrd", n_rd, 4);
    chk("n4_busy_cycles", n_busy, 8);
    chk("n4_ndone", n_done, 1);
    chk("n4_done_after_start", done_at - start_c, 9);
    chk("n4_done_after_busy", done_at - first_busy, 8);

    // Zero-length run.
    clear_stats(); start_c = cyc;
    start_run(0);
    ticks(3);
    chk("n0_nrd", n_rd, 0);
    chk("n0_nwr", n_wr, 0);
    chk("n0_busy", n_busy, 0);
    chk("n0_ndone", n_done, 1);
    chk("n0_done_lat", done_at - start_c, 1);

    // Start held through RUN, DRAIN and DONE of an N=3 run.
    clear_stats();
    start_run(3);
    Start = 1'b1; Run_Len = AW'(5);
    ticks(8);
    Start = 1'b0;
    ticks(3);
    check_writes("n3", 3);
    chk("n3_ndone", n_done, 1);

    // Abort wins over Start in IDLE.
    Abort = 1'b1; Start = 1'b1; Run_Len = AW'(5);
    tick();
    Abort = 1'b0; Start = 1'b0;
    chk("abst_busy", PE_Array_Busy, 1'b0);
    chk("abst_rd_en", In_Rd_En, 1'b0);
    ticks(2);

    // Abort in the second RUN cycle of N=6, then an N=2 run.
    clear_stats();
    start_run(6);
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("ab_busy_next", PE_Array_Busy, 1'b0);
    chk("ab_rd_en_next", In_Rd_En, 1'b0);
    chk("ab_in_addr_next", In_Addr, 0);
    ticks(10);
    chk("ab_nwr", n_wr, 0);
    chk("ab_ndone", n_done, 0);
    clear_stats();
    start_run(2);
    ticks(10);
    check_writes("ab_n2", 2);

    // Reset in the first DRAIN cycle.
    clear_stats();
    start_run(3);
    ticks(3);
    chk("rs_in_drain", PE_Array_Busy & !In_Rd_En, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rs_rd_en", In_Rd_En, 1'b0);
    chk("rs_in_addr", In_Addr, 0);
    chk("rs_out_addr", Out_Addr, 0);
    chk("rs_load0", Data0_Load, 0);
    chk("rs_load1", Data1_Load, 0);
    chk("rs_busy", PE_Array_Busy, 1'b0);
    ticks(8);
    chk("rs_nwr", n_wr, 0);
    chk("rs_ndone", n_done, 0);

    // Back-to-back: Start in the cycle after Done.
    start_run(2);
    ticks(6);
    chk("bb_done", Done, 1'b1);
    chk("bb_out_addr_end", Out_Addr, 2);
    tick();
    clear_stats();
    start_run(3);
    chk("bb_in_addr0", In_Addr, 0);
    chk("bb_rd_en0", In_Rd_En, 1'b1);
    chk("bb_out_addr0", Out_Addr, 0);
    ticks(10);
    check_writes("bb", 3);
    chk("bb_ndone", n_done, 1);

    // Maximum run length.
    clear_stats();
    start_run((1 << AW) - 1);
    ticks((1 << AW) - 1 + D + 3);
    check_writes("max", (1 << AW) - 1);
    chk("max_ndone", n_done, 1);
    chk("max_busy", n_busy, (1 << AW) - 1 + D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
